// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared definitions for the decode-to-execute pipeline register:
//   opcode encodings seen by the ALU, immediate width, the forwarding
//   source selector and a helper that decides how an immediate is extended.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int OPCODE_W = 6;
  localparam int IMM_W    = 16;

  // ALU opcode encodings
  localparam logic [OPCODE_W-1:0] OPCODE_ADD   = 6'h00;
  localparam logic [OPCODE_W-1:0] OPCODE_SUB   = 6'h01;
  localparam logic [OPCODE_W-1:0] OPCODE_AND   = 6'h02;
  localparam logic [OPCODE_W-1:0] OPCODE_OR    = 6'h03;
  localparam logic [OPCODE_W-1:0] OPCODE_XOR   = 6'h04;
  localparam logic [OPCODE_W-1:0] OPCODE_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OPCODE_ADDUI = 6'h09;
  localparam logic [OPCODE_W-1:0] OPCODE_LW    = 6'h10;
  localparam logic [OPCODE_W-1:0] OPCODE_SW    = 6'h11;

  // Where a source operand is taken from
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EX   = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

  // Only ADDI sign-extends its immediate; every other immediate user zero-extends.
  function automatic logic imm_is_signed(input logic [OPCODE_W-1:0] opcode);
    return (opcode == OPCODE_ADDI);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
//   Combinational forwarding selector for one source operand.
//   Priority: r0 -> zero, then the ALU result of the instruction in EX
//   (when it writes a non-load result), then the writeback bus, then the
//   register-file read data.
//
//   Ports:
//     rs        source register index
//     rf_data   register-file read data for rs
//     ex_fwd_en EX holds a valid, writing, non-load instruction
//     ex_rd     destination index of the instruction in EX
//     alu_out   ALU result of the instruction in EX
//     wb_we     writeback bus write enable
//     wb_rd     writeback bus destination index
//     wb_data   writeback bus data
//     operand   resolved operand value
// ---------------------------------------------------------------------------
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int REG_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [DATA_W-1:0]    rf_data,
  input  logic                 ex_fwd_en,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  output logic [DATA_W-1:0]    operand
);

  fwd_sel_e sel_s;
  logic     rs_is_zero_s;
  logic     ex_hit_s;
  logic     wb_hit_s;

  assign rs_is_zero_s = (rs == {REG_IDX_W{1'b0}});
  assign ex_hit_s     = ex_fwd_en & (ex_rd == rs);
  assign wb_hit_s     = wb_we & (wb_rd == rs);

  // Pick the operand source; EX wins over WB because it is the younger write.
  always_comb begin
    sel_s = FWD_RF;
    if (rs_is_zero_s) begin
      sel_s = FWD_ZERO;
    end else if (ex_hit_s) begin
      sel_s = FWD_EX;
    end else if (wb_hit_s) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  // Steer the selected source onto the operand.
  always_comb begin
    operand = {DATA_W{1'b0}};
    case (sel_s)
      FWD_ZERO: operand = {DATA_W{1'b0}};
      FWD_EX:   operand = alu_out;
      FWD_WB:   operand = wb_data;
      FWD_RF:   operand = rf_data;
      default:  operand = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute pipeline register feeding the ALU. Accepts one decoded
//   instruction per cycle, resolves both source operands with forwarding from
//   EX and WB, builds the ADDI/ADDUI immediate and inserts a single bubble on
//   a load-use dependency. ex_opcode/ex_a/ex_b drive the ALU directly.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     dec_valid / dec_ready    decode handshake (dec_ready is combinational)
//     dec_opcode, dec_rs_a, dec_rs_b, dec_rd, dec_we, dec_is_load,
//     dec_use_imm, dec_imm     decoded instruction fields
//     rf_a, rf_b               register-file read data for rs_a / rs_b
//     alu_out                  ALU result of the instruction in EX
//     wb_we, wb_rd, wb_data    writeback bus (carries load data)
//     ex_stall                 downstream cannot take a new instruction
//     flush                    kill the instruction in EX and the offered one
//     ex_valid, ex_opcode, ex_a, ex_b, ex_rd, ex_we, ex_is_load
//                              registered EX-stage instruction
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int REG_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [OPCODE_W-1:0]  dec_opcode,
  input  logic [REG_IDX_W-1:0] dec_rs_a,
  input  logic [REG_IDX_W-1:0] dec_rs_b,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_we,
  input  logic                 dec_is_load,
  input  logic                 dec_use_imm,
  input  logic [IMM_W-1:0]     dec_imm,
  input  logic [DATA_W-1:0]    rf_a,
  input  logic [DATA_W-1:0]    rf_b,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 ex_stall,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [OPCODE_W-1:0]  ex_opcode,
  output logic [DATA_W-1:0]    ex_a,
  output logic [DATA_W-1:0]    ex_b,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 ex_we,
  output logic                 ex_is_load
);

  // EX-stage pipeline registers
  logic                 ex_valid_r;
  logic [OPCODE_W-1:0]  ex_opcode_r;
  logic [DATA_W-1:0]    ex_a_r;
  logic [DATA_W-1:0]    ex_b_r;
  logic [REG_IDX_W-1:0] ex_rd_r;
  logic                 ex_we_r;
  logic                 ex_is_load_r;

  // Operand resolution and hazard detection
  logic                 ex_fwd_en_s;
  logic [DATA_W-1:0]    opnd_a_s;
  logic [DATA_W-1:0]    opnd_b_s;
  logic [DATA_W-1:0]    imm_s;
  logic [DATA_W-1:0]    b_sel_s;
  logic                 load_in_ex_s;
  logic                 rs_a_dep_s;
  logic                 rs_b_dep_s;
  logic                 hazard_s;

  // A load's result is not known in EX, so only non-load writers forward alu_out.
  assign ex_fwd_en_s = ex_valid_r & ex_we_r & ~ex_is_load_r;

  fwd_mux #(
    .REG_IDX_W (REG_IDX_W),
    .DATA_W    (DATA_W)
  ) u_fwd_a (
    .rs        (dec_rs_a),
    .rf_data   (rf_a),
    .ex_fwd_en (ex_fwd_en_s),
    .ex_rd     (ex_rd_r),
    .alu_out   (alu_out),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .operand   (opnd_a_s)
  );

  fwd_mux #(
    .REG_IDX_W (REG_IDX_W),
    .DATA_W    (DATA_W)
  ) u_fwd_b (
    .rs        (dec_rs_b),
    .rf_data   (rf_b),
    .ex_fwd_en (ex_fwd_en_s),
    .ex_rd     (ex_rd_r),
    .alu_out   (alu_out),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .operand   (opnd_b_s)
  );

  // Build the immediate: sign-extended for ADDI, zero-extended otherwise.
  always_comb begin
    imm_s = {DATA_W{1'b0}};
    if (imm_is_signed(dec_opcode)) begin
      imm_s = {{(DATA_W-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};
    end else begin
      imm_s = {{(DATA_W-IMM_W){1'b0}}, dec_imm};
    end
  end

  // Second ALU input: immediate replaces rs_b entirely when selected.
  always_comb begin
    b_sel_s = opnd_b_s;
    if (dec_use_imm) begin
      b_sel_s = imm_s;
    end else begin
      b_sel_s = opnd_b_s;
    end
  end

  // Load-use check; rs_b only matters when it is actually read.
  assign load_in_ex_s = ex_valid_r & ex_is_load_r & ex_we_r &
                        (ex_rd_r != {REG_IDX_W{1'b0}});
  assign rs_a_dep_s   = (ex_rd_r == dec_rs_a);
  assign rs_b_dep_s   = ~dec_use_imm & (ex_rd_r == dec_rs_b);
  assign hazard_s     = dec_valid & load_in_ex_s & (rs_a_dep_s | rs_b_dep_s);

  // Handshake stays purely combinational so decode sees the stall in-cycle.
  assign dec_ready = ~ex_stall & ~hazard_s & ~flush;

  // EX pipeline register; a bubble keeps opcode/operands so the ALU inputs stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r   <= 1'b0;
      ex_we_r      <= 1'b0;
      ex_is_load_r <= 1'b0;
      ex_opcode_r  <= {OPCODE_W{1'b0}};
      ex_a_r       <= {DATA_W{1'b0}};
      ex_b_r       <= {DATA_W{1'b0}};
      ex_rd_r      <= {REG_IDX_W{1'b0}};
    end else if (flush) begin
      ex_valid_r   <= 1'b0;
      ex_we_r      <= 1'b0;
      ex_is_load_r <= 1'b0;
    end else if (ex_stall) begin
      ex_valid_r   <= ex_valid_r;
      ex_we_r      <= ex_we_r;
      ex_is_load_r <= ex_is_load_r;
    end else if (hazard_s) begin
      // The load advances to WB; the dependent instruction is re-offered
      // next cycle and picks the load data up from the writeback bus.
      ex_valid_r   <= 1'b0;
      ex_we_r      <= 1'b0;
      ex_is_load_r <= 1'b0;
    end else if (dec_valid) begin
      ex_valid_r   <= 1'b1;
      ex_we_r      <= dec_we;
      ex_is_load_r <= dec_is_load;
      ex_opcode_r  <= dec_opcode;
      ex_a_r       <= opnd_a_s;
      ex_b_r       <= b_sel_s;
      ex_rd_r      <= dec_rd;
    end else begin
      ex_valid_r   <= 1'b0;
      ex_we_r      <= 1'b0;
      ex_is_load_r <= 1'b0;
    end
  end

  assign ex_valid   = ex_valid_r;
  assign ex_opcode  = ex_opcode_r;
  assign ex_a       = ex_a_r;
  assign ex_b       = ex_b_r;
  assign ex_rd      = ex_rd_r;
  assign ex_we      = ex_we_r;
  assign ex_is_load = ex_is_load_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage: directed scenarios with literal
//   expectations plus a randomized run against a behavioural model of the
//   EX-stage contents.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_opcode;
  logic [4:0]  dec_rs_a, dec_rs_b, dec_rd;
  logic        dec_we, dec_is_load, dec_use_imm;
  logic [15:0] dec_imm;
  logic [31:0] rf_a, rf_b, alu_out;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_stall, flush;
  logic        ex_valid, ex_we, ex_is_load;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_rd;

  int checks   = 0;
  int failures = 0;

  // Model of what EX should hold
  logic        m_valid, m_we, m_load;
  logic [5:0]  m_opcode;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
    .dec_use_imm(dec_use_imm), .dec_imm(dec_imm),
    .rf_a(rf_a), .rf_b(rf_b), .alu_out(alu_out),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load)
  );

  // Value a source register should deliver, from the architectural rules.
  function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (m_valid && m_we && !m_load && m_rd == idx) return alu_out;
    if (wb_we && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] model_imm();
    logic [31:0] v;
    v = 32'(dec_imm);
    if (dec_opcode == OPCODE_ADDI && dec_imm >= 16'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic model_hazard();
    logic uses_rd;
    uses_rd = (m_rd == dec_rs_a) || (!dec_use_imm && m_rd == dec_rs_b);
    return dec_valid && m_valid && m_load && m_we && m_rd != 5'd0 && uses_rd;
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic step();
    logic        hz;
    logic [31:0] na, nb;
    @(posedge clk);
    hz = model_hazard();
    na = model_operand(dec_rs_a, rf_a);
    nb = dec_use_imm ? model_imm() : model_operand(dec_rs_b, rf_b);
    if (rst) begin
      m_valid = 1'b0; m_we = 1'b0; m_load = 1'b0;
      m_opcode = 6'd0; m_a = 32'd0; m_b = 32'd0; m_rd = 5'd0;
    end else if (flush || (!ex_stall && (hz || !dec_valid))) begin
      m_valid = 1'b0; m_we = 1'b0; m_load = 1'b0;
    end else if (!ex_stall) begin
      m_valid = 1'b1; m_we = dec_we; m_load = dec_is_load;
      m_opcode = dec_opcode; m_a = na; m_b = nb; m_rd = dec_rd;
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; dec_valid = 1'b0; dec_opcode = OPCODE_ADD;
    dec_rs_a = 5'd0; dec_rs_b = 5'd0; dec_rd = 5'd0;
    dec_we = 1'b0; dec_is_load = 1'b0; dec_use_imm = 1'b0; dec_imm = 16'd0;
    rf_a = 32'd0; rf_b = 32'd0; alu_out = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ex_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic offer(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic ui, input logic [15:0] imm);
    dec_valid = 1'b1; dec_opcode = op; dec_rs_a = ra; dec_rs_b = rb; dec_rd = rd;
    dec_we = we; dec_is_load = ld; dec_use_imm = ui; dec_imm = imm;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({ex_valid, ex_we, ex_is_load} !== 3'b000 || ex_opcode !== 6'd0 || ex_a !== 32'd0 ||
        ex_b !== 32'd0 || ex_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b a=%h b=%h rd=%0d op=%h, expected all zero",
               ex_valid, ex_a, ex_b, ex_rd, ex_opcode);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: dec_ready=%b expected 1", dec_ready);
    end
  endtask

  task automatic test_forward_chain();
    idle();
    offer(OPCODE_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 16'd0);
    rf_a = 32'd5; rf_b = 32'd7;
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_a !== 32'd5 || ex_b !== 32'd7 || ex_rd !== 5'd3) begin
      failures++;
      $display("FAIL add_issue: valid=%b a=%0d b=%0d rd=%0d expected 1/5/7/3", ex_valid, ex_a, ex_b, ex_rd);
    end
    // EX result must beat a conflicting WB write to the same register.
    offer(OPCODE_ADD, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 16'd0);
    rf_a = 32'd99; rf_b = 32'd99; alu_out = 32'd12;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd77;
    #1;
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++; $display("FAIL fwd_ready: dec_ready=%b expected 1", dec_ready);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_a !== 32'd12 || ex_b !== 32'd12 || ex_rd !== 5'd4) begin
      failures++;
      $display("FAIL ex_forward: valid=%b a=%0d b=%0d rd=%0d expected 1/12/12/4", ex_valid, ex_a, ex_b, ex_rd);
    end
    wb_we = 1'b0;
  endtask

  task automatic test_load_use();
    offer(OPCODE_LW, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 16'd4);
    rf_a = 32'h100;
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_a !== 32'h100 || ex_b !== 32'd4) begin
      failures++;
      $display("FAIL load_issue: valid=%b load=%b a=%h b=%h expected 1/1/100/4", ex_valid, ex_is_load, ex_a, ex_b);
    end
    offer(OPCODE_ADD, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 16'd0);
    rf_a = 32'd0; rf_b = 32'd3;
    #1;
    checks++;
    if (dec_ready !== 1'b0) begin
      failures++; $display("FAIL hazard_ready: dec_ready=%b expected 0", dec_ready);
    end
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_opcode !== OPCODE_LW || ex_a !== 32'h100) begin
      failures++;
      $display("FAIL bubble: valid=%b we=%b op=%h a=%h expected 0/0/%h/100", ex_valid, ex_we, ex_opcode, ex_a, OPCODE_LW);
    end
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++; $display("FAIL reoffer_ready: dec_ready=%b expected 1", dec_ready);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_a !== 32'hDEADBEEF || ex_b !== 32'd3 || ex_rd !== 5'd6) begin
      failures++;
      $display("FAIL wb_forward: valid=%b a=%h b=%h rd=%0d expected 1/deadbeef/3/6", ex_valid, ex_a, ex_b, ex_rd);
    end
    wb_we = 1'b0;
  endtask

  task automatic test_immediate();
    offer(OPCODE_ADDI, 5'd2, 5'd9, 5'd7, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    rf_a = 32'd1; rf_b = 32'h1234;
    step();
    checks++;
    if (ex_b !== 32'hFFFF_FFFF || ex_opcode !== OPCODE_ADDI) begin
      failures++; $display("FAIL addi_sext: b=%h expected ffffffff", ex_b);
    end
    offer(OPCODE_ADDUI, 5'd2, 5'd9, 5'd8, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    step();
    checks++;
    if (ex_b !== 32'h0000_FFFF) begin
      failures++; $display("FAIL addui_zext: b=%h expected 0000ffff", ex_b);
    end
    // A load to r7 must not stall an immediate instruction whose unused rs_b is r7.
    offer(OPCODE_LW, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 16'd0);
    step();
    offer(OPCODE_ADDI, 5'd1, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 16'h0010);
    rf_a = 32'd3;
    #1;
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++; $display("FAIL imm_no_hazard: dec_ready=%b expected 1", dec_ready);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_a !== 32'd3 || ex_b !== 32'h10) begin
      failures++; $display("FAIL imm_issue: valid=%b a=%h b=%h expected 1/3/10", ex_valid, ex_a, ex_b);
    end
  endtask

  task automatic test_r0();
    offer(OPCODE_ADD, 5'd0, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0, 16'd0);
    rf_a = 32'd123; rf_b = 32'd3; alu_out = 32'd55;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd9;
    step();
    checks++;
    if (ex_a !== 32'd0 || ex_b !== 32'd3) begin
      failures++; $display("FAIL r0_zero: a=%0d b=%0d expected 0/3", ex_a, ex_b);
    end
    wb_we = 1'b0;
  endtask

  task automatic test_stall_flush();
    offer(OPCODE_ADD, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 16'd0);
    rf_a = 32'h11; rf_b = 32'h22;
    step();
    offer(OPCODE_SUB, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0, 16'd0);
    rf_a = 32'hAA; rf_b = 32'hBB;
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dec_ready !== 1'b0) begin
        failures++; $display("FAIL stall_ready[%0d]: dec_ready=%b expected 0", i, dec_ready);
      end
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_opcode !== OPCODE_ADD || ex_a !== 32'h11 || ex_b !== 32'h22 ||
          ex_rd !== 5'd9 || ex_we !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b op=%h a=%h b=%h rd=%0d expected 1/00/11/22/9",
                 i, ex_valid, ex_opcode, ex_a, ex_b, ex_rd);
      end
    end
    flush = 1'b1;
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_we !== 1'b0) begin
      failures++; $display("FAIL flush_stall: valid=%b we=%b expected 0/0", ex_valid, ex_we);
    end
    flush = 1'b0; ex_stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    offer(OPCODE_XOR, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0, 16'd0);
    rf_a = 32'h5; rf_b = 32'h6;
    step();
    rst = 1'b1; flush = 1'b1; ex_stall = 1'b1;
    step();
    checks++;
    if ({ex_valid, ex_we, ex_is_load} !== 3'b000 || ex_opcode !== 6'd0 || ex_a !== 32'd0 ||
        ex_b !== 32'd0 || ex_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b op=%h a=%h b=%h rd=%0d expected all zero",
               ex_valid, ex_opcode, ex_a, ex_b, ex_rd);
    end
    idle();
    #1;
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_ready: dec_ready=%b expected 1", dec_ready);
    end
  endtask

  task automatic test_random();
    logic exp_ready;
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(63, 0) == 0);
      flush       = ($urandom_range(15, 0) == 0);
      ex_stall    = ($urandom_range(7, 0) == 0);
      dec_valid   = ($urandom_range(3, 0) != 0);
      case ($urandom_range(5, 0))
        0: dec_opcode = OPCODE_ADD;
        1: dec_opcode = OPCODE_SUB;
        2: dec_opcode = OPCODE_ADDI;
        3: dec_opcode = OPCODE_ADDUI;
        4: dec_opcode = OPCODE_LW;
        default: dec_opcode = OPCODE_OR;
      endcase
      dec_is_load = (dec_opcode == OPCODE_LW);
      dec_use_imm = dec_is_load || ($urandom_range(1, 0) == 1);
      dec_rs_a    = 5'($urandom_range(3, 0));
      dec_rs_b    = 5'($urandom_range(3, 0));
      dec_rd      = 5'($urandom_range(3, 0));
      dec_we      = ($urandom_range(4, 0) != 0);
      dec_imm     = 16'($urandom);
      rf_a        = $urandom;
      rf_b        = $urandom;
      alu_out     = $urandom;
      wb_we       = ($urandom_range(1, 0) == 1);
      wb_rd       = 5'($urandom_range(3, 0));
      wb_data     = $urandom;
      #1;
      exp_ready = !ex_stall && !flush && !model_hazard();
      checks++;
      if (dec_ready !== exp_ready) begin
        failures++; $display("FAIL rnd_ready[%0d]: dec_ready=%b expected %b", n, dec_ready, exp_ready);
      end
      step();
      checks++;
      if (ex_valid !== m_valid || ex_we !== m_we || ex_is_load !== m_load || ex_rd !== m_rd ||
          ex_opcode !== m_opcode || ex_a !== m_a || ex_b !== m_b) begin
        failures++;
        $display("FAIL rnd_state[%0d]: got v=%b we=%b ld=%b rd=%0d op=%h a=%h b=%h expected v=%b we=%b ld=%b rd=%0d op=%h a=%h b=%h",
                 n, ex_valid, ex_we, ex_is_load, ex_rd, ex_opcode, ex_a, ex_b,
                 m_valid, m_we, m_load, m_rd, m_opcode, m_a, m_b);
      end
    end
  endtask

  initial begin
    m_valid = 1'b0; m_we = 1'b0; m_load = 1'b0;
    m_opcode = 6'd0; m_a = 32'd0; m_b = 32'd0; m_rd = 5'd0;
    test_reset();
    test_forward_chain();
    test_load_use();
    test_immediate();
    test_r0();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
